led_ctrl_fsm_mealy2_two_segment: RTL and testbench

LED_CTRL_FSM_MEALY2_TWO_SEGMENT -- requirements
Module: led_ctrl_fsm_mealy2_two_segment

---
 rtl/led_ctrl_fsm_mealy2_two_segment.sv | 63 ++++++
 tb/tb_led_ctrl_fsm_mealy2_two_segment.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/led_ctrl_fsm_mealy2_two_segment.sv
// led_ctrl_fsm_mealy2_two_segment
//   Touch-toggled LED built as a two-state Mealy FSM, coded in two segments:
//   a state register and one combinational block that produces both the
//   next state and the LED drive. Every sampled touch toggles the state.
//   led shows the post-touch value in the same cycle the touch is present.
// Parameters:
//   LED_INIT  - state entered on reset (0 = LED off, 1 = LED on)
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   key_touch - touch request, one toggle per high sample
//   led       - LED drive, 1 = on
module led_ctrl_fsm_mealy2_two_segment #(
  parameter logic LED_INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_touch,
  output logic led
);

  typedef enum logic {
    S_OFF = 1'b0,
    S_ON  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = state_t'(LED_INIT);

  state_t state;
  state_t state_next;
  logic   touch;

  // A touch seen while reset is held must not show on led either.
  assign touch = key_touch & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_STATE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = S_OFF;
    led        = 1'b0;
    case (state)
      S_OFF: begin
        state_next = touch ? S_ON : S_OFF;
        led        = touch;
      end
      S_ON: begin
        state_next = touch ? S_OFF : S_ON;
        led        = ~touch;
      end
      default: begin
        state_next = S_OFF;
        led        = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_led_ctrl_fsm_mealy2_two_segment.sv
`timescale 1ns/1ps
module tb_led_ctrl_fsm_mealy2_two_segment;

  logic clk = 1'b0;
  logic rst_n;
  logic key_touch;
  logic led0;
  logic led1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model: the LED is on when (initial value + number of counted touches)
  // is odd, inverted combinationally while a counted touch is present.
  int unsigned touches = 0;

  always #10 clk = ~clk;

  led_ctrl_fsm_mealy2_two_segment #(.LED_INIT(1'b0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_touch (key_touch),
    .led       (led0)
  );

  led_ctrl_fsm_mealy2_two_segment #(.LED_INIT(1'b1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_touch (key_touch),
    .led       (led1)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) touches = 0;
    else if (key_touch === 1'b1) touches = touches + 1;
  end

  function automatic logic model_led(input int unsigned init);
    int unsigned total;
    logic        live_touch;
    total      = init + touches;
    live_touch = (key_touch === 1'b1) && (rst_n === 1'b1);
    return ((total % 2) == 1) ^ live_touch;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_led0", led0, model_led(0));
    check("model_led1", led1, model_led(1));
  end

  task automatic drive_key(input logic v);
    @(posedge clk);
    #1 key_touch = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #5 rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    key_touch = 1'b0;

    // Reset held 122 ns
    @(negedge clk);
    check("rst_led0", led0, 1'b0);
    check("rst_led1", led1, 1'b1);
    #(122 - 20) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_led0", led0, 1'b0);
    check("post_rst_led1", led1, 1'b1);

    // Single pulse
    drive_key(1'b1);
    @(negedge clk);
    check("pulse_during_led0", led0, 1'b1);
    check("pulse_during_led1", led1, 1'b0);
    drive_key(1'b0);
    @(negedge clk);
    check("pulse_after_led0", led0, 1'b1);
    check("pulse_after_led1", led1, 1'b0);
    repeat (2) @(negedge clk);
    check("pulse_hold_led0", led0, 1'b1);

    // Held input for 3 cycles from S_OFF
    do_reset();
    drive_key(1'b1);
    @(negedge clk);
    check("held_c1_led0", led0, 1'b1);
    @(negedge clk);
    check("held_c2_led0", led0, 1'b0);
    @(negedge clk);
    check("held_c3_led0", led0, 1'b1);
    drive_key(1'b0);
    @(negedge clk);
    check("held_release_led0", led0, 1'b1);
    check("held_release_led1", led1, 1'b0);

    // Mid-operation asynchronous reset while in S_ON, with a coincident touch
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_led0", led0, 1'b0);
    check("async_rst_led1", led1, 1'b1);
    drive_key(1'b1);
    @(negedge clk);
    check("rst_touch_led0", led0, 1'b0);
    check("rst_touch_led1", led1, 1'b1);
    drive_key(1'b0);
    @(negedge clk);
    #5 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_idle_led0", led0, 1'b0);
    check("rst_idle_led1", led1, 1'b1);
    drive_key(1'b1);
    drive_key(1'b0);
    @(negedge clk);
    check("first_touch_led0", led0, 1'b1);
    check("first_touch_led1", led1, 1'b0);

    // Periodic pulses: one every 7 clocks, 1024 iterations
    do_reset();
    for (int i = 1; i <= 1024; i++) begin
      drive_key(1'b1);
      drive_key(1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("periodic_led0", led0, logic'(i % 2));
    end
    check("periodic_final_led0", led0, 1'b0);
    check("periodic_final_led1", led1, 1'b1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
